// File: rtl/gpu_rect_fill_if.sv
// gpu_rect_fill_if -- command and VRAM write bus for the rectangle fill engine.
//   Command side : start_i (1-cycle strobe), x_i/y_i (top-left), w_i/h_i
//                  (size), color_i (fill byte).
//   Status side  : busy_o (writes in progress), done_o (1-cycle completion).
//   VRAM side    : v_we_o, v_addr_o (15-bit byte address), v_data_o.
// master = command issuer / VRAM sink, slave = fill engine.
interface gpu_rect_fill_if;
  logic        start_i;
  logic [7:0]  x_i;
  logic [7:0]  y_i;
  logic [7:0]  w_i;
  logic [7:0]  h_i;
  logic [7:0]  color_i;
  logic        busy_o;
  logic        done_o;
  logic        v_we_o;
  logic [14:0] v_addr_o;
  logic [7:0]  v_data_o;

  modport master (
    output start_i, x_i, y_i, w_i, h_i, color_i,
    input  busy_o, done_o, v_we_o, v_addr_o, v_data_o
  );

  modport slave (
    input  start_i, x_i, y_i, w_i, h_i, color_i,
    output busy_o, done_o, v_we_o, v_addr_o, v_data_o
  );
endinterface

// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill -- fills a clipped rectangle of an H_RES x V_RES byte
// framebuffer with one colour, one VRAM write per clock.
//   clk   : sole clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : gpu_rect_fill_if.slave -- command inputs, busy/done status and
//           the VRAM write port (v_we_o / v_addr_o / v_data_o)
// Every output is a flop; nothing on the command inputs reaches an output
// combinationally.
module gpu_rect_fill #(
  parameter int H_RES = 200,
  parameter int V_RES = 150
) (
  input  logic           clk,
  input  logic           rst,
  gpu_rect_fill_if.slave bus
);

  localparam logic [8:0]  H_END  = 9'(H_RES);
  localparam logic [8:0]  V_END  = 9'(V_RES);
  localparam logic [14:0] H_STEP = 15'(H_RES);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  col_q, col_d;           // current column
  logic [8:0]  row_q, row_d;           // current row
  logic [8:0]  col_start_q, col_start_d; // left column, reloaded each row
  logic [8:0]  col_end_q, col_end_d;   // clipped exclusive column end
  logic [8:0]  row_end_q, row_end_d;   // clipped exclusive row end
  logic [14:0] row_base_q, row_base_d; // row * H_RES, kept incrementally
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Command decode, only meaningful in IDLE with start_i high.
  // Ends are formed at 9 bits so x+w / y+h cannot wrap before clipping.
  logic [8:0]  x_ext, y_ext, col_sum, row_sum, col_clip, row_clip;
  logic [14:0] start_base;
  logic        cmd_empty;
  logic [8:0]  col_nxt, row_nxt;

  always_comb begin
    x_ext    = {1'b0, bus.x_i};
    y_ext    = {1'b0, bus.y_i};
    col_sum  = x_ext + {1'b0, bus.w_i};
    row_sum  = y_ext + {1'b0, bus.h_i};
    col_clip = (col_sum > H_END) ? H_END : col_sum;
    row_clip = (row_sum > V_END) ? V_END : row_sum;
    // One multiply per command to seed the row base; per-pixel and per-row
    // addressing after that is add-only.
    start_base = 15'(bus.y_i) * H_STEP;
    cmd_empty  = (bus.w_i == 8'd0) || (bus.h_i == 8'd0) ||
                 (x_ext >= H_END) || (y_ext >= V_END);
    col_nxt    = col_q + 9'd1;
    row_nxt    = row_q + 9'd1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_end_d   = row_end_q;
    row_base_d  = row_base_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          col_start_d = x_ext;
          col_end_d   = col_clip;
          row_end_d   = row_clip;
          data_d      = bus.color_i;
          if (cmd_empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // First pixel is presented in the very next cycle.
            state_d    = FILL;
            we_d       = 1'b1;
            busy_d     = 1'b1;
            col_d      = x_ext;
            row_d      = y_ext;
            row_base_d = start_base;
            addr_d     = start_base + {6'd0, x_ext};
          end
        end
      end

      FILL: begin
        // The flops hold the pixel being written now; pick the one after it.
        if (col_nxt < col_end_q) begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          col_d  = col_nxt;
          addr_d = addr_q + 15'd1;
        end else if (row_nxt < row_end_q) begin
          we_d       = 1'b1;
          busy_d     = 1'b1;
          row_d      = row_nxt;
          col_d      = col_start_q;
          row_base_d = row_base_q + H_STEP;
          addr_d     = row_base_q + H_STEP + {6'd0, col_start_q};
        end else begin
          // Last pixel is on the bus this cycle.
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      col_start_q <= '0;
      col_end_q   <= '0;
      row_end_q   <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_end_q   <= row_end_d;
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.v_we_o   = we_q;
  assign bus.v_addr_o = addr_q;
  assign bus.v_data_o = data_q;

endmodule

// File: doc/gpu_rect_fill.md
GPU_RECT_FILL -- requirements
Module: gpu_rect_fill

Interface
REQ-001 SHALL have parameter H_RES, default 200, meaning framebuffer columns.
REQ-002 SHALL have parameter V_RES, default 150, meaning framebuffer rows.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  single-cycle command strobe.
REQ-006 SHALL have port x_i  input  8  left column of the rectangle.
REQ-007 SHALL have port y_i  input  8  top row of the rectangle.
REQ-008 SHALL have port w_i  input  8  width in pixels.
REQ-009 SHALL have port h_i  input  8  height in pixels.
REQ-010 SHALL have port color_i  input  8  fill colour byte.
REQ-011 SHALL have port busy_o  output  1  high while fill writes are being issued.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port v_we_o  output  1  VRAM write enable, drives the GPU v_we_i.
REQ-014 SHALL have port v_addr_o  output  15  VRAM byte address, drives the GPU v_addr_i.
REQ-015 SHALL have port v_data_o  output  8  VRAM write data, drives the GPU v_data_i.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, DONE.
REQ-017 SHALL accept start_i only in IDLE; start_i in FILL or DONE is ignored with no effect on the current command.
REQ-018 SHALL latch x_i, y_i, w_i, h_i and color_i on the edge that accepts start_i; later input changes have no effect on that command.
REQ-019 SHALL clip the rectangle to the framebuffer:
  - column end = min(x+w, H_RES), row end = min(y+h, V_RES);
  - end computed at 9 bits, so there is no 8-bit overflow.
REQ-020 SHALL go IDLE -> DONE, issuing no writes, when the clipped area is empty (w=0, h=0, x>=H_RES or y>=V_RES).
REQ-021 SHALL otherwise go IDLE -> FILL, with the first write (v_we_o=1) in the cycle after the accepting edge.
REQ-022 SHALL issue exactly one write per cycle in FILL, with no gaps:
  - raster order, column fastest, then next row;
  - v_addr_o = row*H_RES + col;
  - v_data_o = latched colour.
REQ-023 SHALL generate addresses incrementally (row base += H_RES per row), with no per-pixel multiplier.
REQ-024 SHALL go FILL -> DONE on the edge after the write to (clipped end column-1, clipped end row-1).
REQ-025 SHALL assert done_o for exactly one cycle in DONE, then go to IDLE.
REQ-026 SHALL hold busy_o=1 exactly while in FILL.
REQ-027 SHALL hold v_we_o=0 outside FILL.
REQ-028 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on rst asserted at any time (including mid-FILL), immediately force:
  - state IDLE;
  - busy_o=0, done_o=0, v_we_o=0;
  - v_addr_o=0, v_data_o=0;
  - all counters to 0.
REQ-030 SHALL not complete an interrupted fill after reset and SHALL not pulse done_o for it.
REQ-031 SHALL accept a new start_i on the first clock edge after rst deasserts.

Verification
REQ-032 SHALL cover basic fill: x=2, y=1, w=3, h=2, colour=0xA5.
  - Response: six writes on consecutive cycles to addresses 202, 203, 204, 402, 403, 404, data 0xA5.
  - done_o pulses the cycle after address 404.
REQ-033 SHALL cover clipping: x=198, y=149, w=5, h=4.
  - Response: exactly two writes, to 29998 and 29999, then done_o.
REQ-034 SHALL cover empty commands: w=0 (and separately x=200) -> zero writes, done_o one cycle later, busy_o never high.
REQ-035 SHALL cover start while busy: start_i during an active 10x10 fill with other operands.
  - Response: exactly 100 writes of the original colour and a single done_o.
REQ-036 SHALL cover reset mid-fill: rst asserted after the 5th write of a 4x4 fill.
  - Response: v_we_o=0 and busy_o=0 immediately, no further writes, no done_o.
  - A following 1x1 command at (0,0) writes address 0.
REQ-037 SHALL cover full screen: x=0, y=0, w=200, h=150.
  - Response: 30000 consecutive writes, addresses 0..29999, busy_o high for exactly 30000 cycles.
